// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH edge-aligned PWM outputs sharing one prescaler and period counter,
// with duty/period/prescale/enable double-buffered and applied only on a period boundary.
module pwm_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [PRESC_W-1:0]      cfg_prescale,
    input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
    input  logic [NUM_CH-1:0]       cfg_ch_en,
    input  logic [NUM_CH-1:0]       ch_pol,
    output logic                    cfg_pending,
    output logic                    period_start,
    output logic [NUM_CH-1:0]       pwm_out
);
    logic [CNT_W-1:0]        pendPeriod, actPeriod, cnt;
    logic [PRESC_W-1:0]      pendPresc, actPresc, psc;
    logic [NUM_CH*CNT_W-1:0] pendDuty, actDuty;
    logic [NUM_CH-1:0]       pendChEn, actChEn, raw;
    logic                    tick, wrap, apply, startQ, enQ;

    assign tick  = en && (psc == actPresc);
    assign wrap  = tick && (cnt == actPeriod);
    assign apply = cfg_pending && (wrap || !en);
    // enQ resets high so the cycle right after reset never shows an enable-rise pulse
    assign period_start = startQ || (en && !enQ);

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++)
            raw[i] = actChEn[i] && en && (cnt < actDuty[i*CNT_W +: CNT_W]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc         <= '0;
            cnt         <= '0;
            pendPeriod  <= '0;
            pendPresc   <= '0;
            pendDuty    <= '0;
            pendChEn    <= '0;
            actPeriod   <= '0;
            actPresc    <= '0;
            actDuty     <= '0;
            actChEn     <= '0;
            cfg_pending <= 1'b0;
            startQ      <= 1'b0;
            enQ         <= 1'b1;
            pwm_out     <= '0;
        end else begin
            psc         <= (!en || tick) ? '0 : psc + 1'b1;
            cnt         <= !en ? '0 : tick ? (wrap ? '0 : cnt + 1'b1) : cnt;
            startQ      <= wrap;
            enQ         <= en;
            cfg_pending <= cfg_load || (cfg_pending && !apply);
            pwm_out     <= raw ^ ch_pol;
            if (cfg_load) begin
                pendPeriod <= cfg_period;
                pendPresc  <= cfg_prescale;
                pendDuty   <= cfg_duty;
                pendChEn   <= cfg_ch_en;
            end
            if (apply) begin
                actPeriod <= pendPeriod;
                actPresc  <= pendPresc;
                actDuty   <= pendDuty;
                actChEn   <= pendChEn;
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed bench for pwm_multi with NUM_CH=4, CNT_W=8, PRESC_W=8.
module tb_pwm_multi;
    logic        clk = 1'b0;
    logic        reset, en, cfgLoad;
    logic [7:0]  cfgPeriod, cfgPrescale;
    logic [31:0] cfgDuty;
    logic [3:0]  cfgChEn, chPol;
    logic        cfgPending, periodStart;
    logic [3:0]  pwmOut;
    int          errors = 0;
    int          checks = 0;

    pwm_multi #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_load(cfgLoad),
        .cfg_period(cfgPeriod), .cfg_prescale(cfgPrescale), .cfg_duty(cfgDuty),
        .cfg_ch_en(cfgChEn), .ch_pol(chPol),
        .cfg_pending(cfgPending), .period_start(periodStart), .pwm_out(pwmOut)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Loads a config while disabled (applied on the following edge), then raises en.
    task automatic setup(input logic [7:0] per, input logic [7:0] pre, input logic [31:0] duty,
                         input logic [3:0] chEn);
        en = 1'b0; cfgPeriod = per; cfgPrescale = pre; cfgDuty = duty; cfgChEn = chEn; cfgLoad = 1'b1;
        cyc(1);
        cfgLoad = 1'b0;
        cyc(1);
        en = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; cfgLoad = 1'b1; chPol = 4'b0;
        cfgPeriod = 8'd9; cfgPrescale = 8'd0; cfgDuty = 32'hFFFF_FFFF; cfgChEn = 4'hF;
        cyc(2);
        checks++; if (pwmOut !== 4'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0000", pwmOut); end
        checks++; if (cfgPending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", cfgPending); end
        checks++; if (periodStart !== 1'b0) begin errors++; $display("FAIL reset_pstart got=%b exp=0", periodStart); end
        reset = 1'b0; cfgLoad = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic;
        logic [3:0] e;
        setup(8'd9, 8'd0, {8'd255, 8'd10, 8'd3, 8'd0}, 4'hF);
        checks++; if (periodStart !== 1'b1) begin errors++; $display("FAIL basic_en_rise_pstart got=%b exp=1", periodStart); end
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            e = {1'b1, 1'b1, ((k - 1) % 10) < 3, 1'b0};
            checks++; if (pwmOut !== e) begin errors++; $display("FAIL basic_pwm k=%0d got=%b exp=%b", k, pwmOut, e); end
            checks++; if (periodStart !== (k % 10 == 0)) begin errors++; $display("FAIL basic_pstart k=%0d got=%b exp=%b", k, periodStart, k % 10 == 0); end
        end
    endtask

    task automatic test_prescale;
        logic [3:0] e;
        setup(8'd4, 8'd3, {24'd0, 8'd2}, 4'b0001);
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            e = {3'b000, ((k - 1) % 20) < 8};
            checks++; if (pwmOut !== e) begin errors++; $display("FAIL presc_pwm k=%0d got=%b exp=%b", k, pwmOut, e); end
            checks++; if (periodStart !== (k % 20 == 0)) begin errors++; $display("FAIL presc_pstart k=%0d got=%b exp=%b", k, periodStart, k % 20 == 0); end
        end
    endtask

    task automatic test_shadow;
        logic e;
        setup(8'd9, 8'd0, {24'd0, 8'd3}, 4'b0001);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            e = (k <= 10) ? ((k - 1) < 3) : ((k - 11) < 7);
            checks++; if (pwmOut !== {3'b000, e}) begin errors++; $display("FAIL shadow_pwm k=%0d got=%b exp=%b", k, pwmOut, {3'b000, e}); end
            checks++; if (cfgPending !== (k >= 5 && k <= 9)) begin errors++; $display("FAIL shadow_pending k=%0d got=%b exp=%b", k, cfgPending, k >= 5 && k <= 9); end
            if (k == 4) begin cfgDuty = {24'd0, 8'd5}; cfgLoad = 1'b1; end
            if (k == 5) cfgLoad = 1'b0;
            if (k == 6) begin cfgDuty = {24'd0, 8'd7}; cfgLoad = 1'b1; end
            if (k == 7) cfgLoad = 1'b0;
        end
    endtask

    task automatic test_disable;
        en = 1'b0; chPol = 4'b0101;
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            checks++; if (pwmOut !== 4'b0101) begin errors++; $display("FAIL dis_pwm k=%0d got=%b exp=0101", k, pwmOut); end
            checks++; if (periodStart !== 1'b0) begin errors++; $display("FAIL dis_pstart k=%0d got=%b exp=0", k, periodStart); end
        end
        cfgPeriod = 8'd9; cfgPrescale = 8'd0; cfgDuty = 32'd0; cfgChEn = 4'hF; cfgLoad = 1'b1;
        cyc(1);
        cfgLoad = 1'b0;
        checks++; if (cfgPending !== 1'b1) begin errors++; $display("FAIL dis_pending_set got=%b exp=1", cfgPending); end
        cyc(1);
        checks++; if (cfgPending !== 1'b0) begin errors++; $display("FAIL dis_pending_clr got=%b exp=0", cfgPending); end
        en = 1'b1;
        #1;
        checks++; if (periodStart !== 1'b1) begin errors++; $display("FAIL dis_en_rise_pstart got=%b exp=1", periodStart); end
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            checks++; if (pwmOut !== 4'b0101) begin errors++; $display("FAIL dis_duty0_pwm k=%0d got=%b exp=0101", k, pwmOut); end
        end
    endtask

    task automatic test_reset_mid;
        chPol = 4'b0;
        setup(8'd9, 8'd0, {24'd0, 8'd3}, 4'b0001);
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            if (k == 5) begin cfgDuty = {24'd0, 8'd9}; cfgLoad = 1'b1; end
        end
        cfgLoad = 1'b0;
        checks++; if (cfgPending !== 1'b1) begin errors++; $display("FAIL rmid_pending_before got=%b exp=1", cfgPending); end
        reset = 1'b1;
        cyc(1);
        checks++; if (pwmOut !== 4'b0) begin errors++; $display("FAIL rmid_pwm got=%b exp=0000", pwmOut); end
        checks++; if (cfgPending !== 1'b0) begin errors++; $display("FAIL rmid_pending got=%b exp=0", cfgPending); end
        checks++; if (periodStart !== 1'b0) begin errors++; $display("FAIL rmid_pstart got=%b exp=0", periodStart); end
        reset = 1'b0;
        for (int k = 8; k <= 20; k++) begin
            cyc(1);
            checks++; if (pwmOut !== 4'b0) begin errors++; $display("FAIL rmid_stale_pwm k=%0d got=%b exp=0000", k, pwmOut); end
            checks++; if (cfgPending !== 1'b0) begin errors++; $display("FAIL rmid_stale_pending k=%0d got=%b exp=0", k, cfgPending); end
            if (k >= 9) begin
                checks++; if (periodStart !== 1'b1) begin errors++; $display("FAIL rmid_pstart_p0 k=%0d got=%b exp=1", k, periodStart); end
            end
        end
    endtask

    task automatic test_period0;
        logic e;
        setup(8'd0, 8'd0, {24'd0, 8'd1}, 4'b0001);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            e = (k <= 12);
            checks++; if (pwmOut !== {3'b000, e}) begin errors++; $display("FAIL p0_pwm k=%0d got=%b exp=%b", k, pwmOut, {3'b000, e}); end
            checks++; if (periodStart !== 1'b1) begin errors++; $display("FAIL p0_pstart k=%0d got=%b exp=1", k, periodStart); end
            checks++; if (cfgPending !== (k == 11)) begin errors++; $display("FAIL p0_pending k=%0d got=%b exp=%b", k, cfgPending, k == 11); end
            if (k == 10) begin cfgDuty = 32'd0; cfgLoad = 1'b1; end
            if (k == 11) cfgLoad = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_prescale;
        test_shadow;
        test_disable;
        test_reset_mid;
        test_period0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
